// File: rtl/cmd_dispatch.sv
// Remote-command sequencer: assembles 3-byte UART packets for cmd_cfg, injects
// EMER_LAND when the host link goes silent while armed, and forwards responses.
module cmd_dispatch #(
  parameter bit          FAST_SIM   = 1'b1,
  parameter int unsigned BYTE_TMO_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy_i,
  input  logic [7:0]  rx_data_i,
  output logic        clr_rx_rdy_o,
  output logic        cmd_rdy_o,
  output logic [7:0]  cmd_o,
  output logic [15:0] data_o,
  input  logic        clr_cmd_rdy_i,
  input  logic        motors_off_i,
  input  logic [7:0]  resp_i,
  input  logic        send_resp_i,
  output logic        trmt_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_i,
  output logic        wdog_trip_o,
  output logic        pkt_drop_o
);

  localparam logic [7:0]            EmerLand = 8'h07;
  localparam logic [BYTE_TMO_W-1:0] GapOne   = 1;

  typedef enum logic [1:0] {StWaitCmd, StWaitHi, StWaitLo, StHold} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [15:0]           data_q, data_d;
  logic [25:0]           wdog_q, wdog_d;
  logic [BYTE_TMO_W-1:0] gap_q, gap_d;
  logic                  injected_q, injected_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            pend_q, pend_d;
  logic [7:0]            tx_last_q, tx_last_d;

  logic wdog_full, gap_full, armed, pkt_done, inject, tx_free, trmt;

  assign wdog_full = FAST_SIM ? &wdog_q[8:0] : &wdog_q;
  assign gap_full  = &gap_q;
  assign armed     = ~motors_off_i;

  // Packet assembly and EMER_LAND injection
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    injected_d   = injected_q;
    gap_d        = '0;
    clr_rx_rdy_o = 1'b0;
    wdog_trip_o  = 1'b0;
    pkt_drop_o   = 1'b0;
    pkt_done     = 1'b0;
    inject       = 1'b0;
    unique case (state_q)
      StWaitCmd: begin
        if (rx_rdy_i) begin
          clr_rx_rdy_o = 1'b1;
          cmd_d        = rx_data_i;
          state_d      = StWaitHi;
        end else if (wdog_full && armed) begin
          cmd_d       = EmerLand;
          data_d      = '0;
          injected_d  = 1'b1;
          wdog_trip_o = 1'b1;
          inject      = 1'b1;
          state_d     = StHold;
        end
      end
      StWaitHi: begin
        if (rx_rdy_i) begin
          clr_rx_rdy_o = 1'b1;
          data_d[15:8] = rx_data_i;
          state_d      = StWaitLo;
        end else if (gap_full || (wdog_full && armed)) begin
          pkt_drop_o = 1'b1;
          state_d    = StWaitCmd;
        end else begin
          gap_d = gap_q + GapOne;
        end
      end
      StWaitLo: begin
        if (rx_rdy_i) begin
          clr_rx_rdy_o = 1'b1;
          data_d[7:0]  = rx_data_i;
          injected_d   = 1'b0;
          pkt_done     = 1'b1;
          state_d      = StHold;
        end else if (gap_full || (wdog_full && armed)) begin
          pkt_drop_o = 1'b1;
          state_d    = StWaitCmd;
        end else begin
          gap_d = gap_q + GapOne;
        end
      end
      StHold: begin
        // Bytes arriving while cmd_cfg owns the packet are consumed and dropped
        if (rx_rdy_i) begin
          clr_rx_rdy_o = 1'b1;
          pkt_drop_o   = 1'b1;
        end
        if (clr_cmd_rdy_i) begin
          state_d = StWaitCmd;
        end
      end
      default: state_d = StWaitCmd;
    endcase
  end

  // Saturating watchdog; paused while cmd_cfg holds a packet
  always_comb begin
    wdog_d = wdog_q;
    if (pkt_done || inject) begin
      wdog_d = '0;
    end else if (state_q != StHold && !wdog_full) begin
      wdog_d = wdog_q + 26'd1;
    end
  end

  // Response path with a 1-deep pending buffer; a done cycle counts as idle
  always_comb begin
    trmt       = 1'b0;
    tx_busy_d  = tx_busy_q & ~tx_done_i;
    tx_free    = ~tx_busy_d;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    tx_last_d  = tx_last_q;
    if (tx_free && pend_vld_q) begin
      trmt       = 1'b1;
      tx_last_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    if (send_resp_i && !injected_q) begin
      if (tx_free && !pend_vld_q) begin
        trmt      = 1'b1;
        tx_last_d = resp_i;
      end else begin
        pend_d     = resp_i;
        pend_vld_d = 1'b1;
      end
    end
    if (trmt) begin
      tx_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitCmd;
      cmd_q      <= '0;
      data_q     <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      injected_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      tx_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      injected_q <= injected_d;
      tx_busy_q  <= tx_busy_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign cmd_rdy_o = (state_q == StHold);
  assign cmd_o     = cmd_q;
  assign data_o    = data_q;
  assign trmt_o    = trmt;
  assign tx_data_o = tx_last_d;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed scenarios plus randomized
// packet and response traffic checked against a transaction-level model.
module tb_cmd_dispatch;

  localparam int TmoW     = 10;
  localparam int GapLimit = 1 << TmoW;
  localparam int WdogFull = 511;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy = 1'b0;
  logic        motors_off = 1'b1;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        wdog_trip;
  logic        pkt_drop;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_dispatch #(
    .FAST_SIM  (1'b1),
    .BYTE_TMO_W(TmoW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_rdy_i     (rx_rdy),
    .rx_data_i    (rx_data),
    .clr_rx_rdy_o (clr_rx_rdy),
    .cmd_rdy_o    (cmd_rdy),
    .cmd_o        (cmd),
    .data_o       (data),
    .clr_cmd_rdy_i(clr_cmd_rdy),
    .motors_off_i (motors_off),
    .resp_i       (resp),
    .send_resp_i  (send_resp),
    .trmt_o       (trmt),
    .tx_data_o    (tx_data),
    .tx_done_i    (tx_done),
    .wdog_trip_o  (wdog_trip),
    .pkt_drop_o   (pkt_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    tx_done     = 1'b0;
  endtask

  // Leaves the bench at the negedge on which rst_n was released.
  task automatic do_reset(input logic mo);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    motors_off = mo;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one byte for one cycle starting at a negedge; returns at the next negedge.
  task automatic drive_byte(input logic [7:0] b, output logic clr, output logic drop,
                            output logic trip);
    rx_rdy  = 1'b1;
    rx_data = b;
    #1;
    clr  = clr_rx_rdy;
    drop = pkt_drop;
    trip = wdog_trip;
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy);
    end
    n_tests++;
    if (cmd !== 8'h00 || data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_cmd_data: got %h/%h expected 00/0000", cmd, data);
    end
    n_tests++;
    if (trmt !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx: got trmt=%b tx_data=%h expected 0/00", trmt, tx_data);
    end
    n_tests++;
    if (clr_rx_rdy !== 1'b0 || wdog_trip !== 1'b0 || pkt_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got clr=%b trip=%b drop=%b expected 000",
               clr_rx_rdy, wdog_trip, pkt_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic c, d, t;
    do_reset(1'b1);
    drive_byte(8'hAA, c, d, t);
    drive_byte(8'hBB, c, d, t);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (cmd_rdy !== 1'b0 || cmd !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_clear: got rdy=%b cmd=%h expected 0/00", cmd_rdy, cmd);
    end
    @(negedge clk);
    drive_byte(8'h11, c, d, t);
    drive_byte(8'h22, c, d, t);
    drive_byte(8'h33, c, d, t);
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h11 || data !== 16'h2233) begin
      n_fail++;
      $display("FAIL reset_mid_pkt: got rdy=%b %h/%h expected 1 11/2233", cmd_rdy, cmd, data);
    end
  endtask

  // Random packets, random inter-byte gaps (0 = back-to-back), random HOLD traffic.
  task automatic test_packets();
    logic c, d, t;
    logic [7:0] b [3];
    logic [7:0] junk;
    do_reset(1'b0);
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        drive_byte(b[k], c, d, t);
        n_tests++;
        if (c !== 1'b1 || d !== 1'b0 || t !== 1'b0) begin
          n_fail++;
          $display("FAIL pkt_byte_ack: got clr=%b drop=%b trip=%b expected 1 0 0", c, d, t);
        end
        if (k < 2) begin
          n_tests++;
          if (cmd_rdy !== 1'b0) begin
            n_fail++; $display("FAIL pkt_early_rdy: got %b expected 0 after byte %0d", cmd_rdy, k);
          end
        end
      end
      #1;
      n_tests++;
      if (cmd_rdy !== 1'b1 || cmd !== b[0] || data !== {b[1], b[2]}) begin
        n_fail++;
        $display("FAIL pkt_contents: got rdy=%b %h/%h expected 1 %h/%h%h",
                 cmd_rdy, cmd, data, b[0], b[1], b[2]);
      end
      @(negedge clk);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom);
        drive_byte(junk, c, d, t);
        n_tests++;
        if (c !== 1'b1 || d !== 1'b1) begin
          n_fail++; $display("FAIL hold_rx_drop: got clr=%b drop=%b expected 1 1", c, d);
        end
        n_tests++;
        if (cmd_rdy !== 1'b1 || cmd !== b[0] || data !== {b[1], b[2]}) begin
          n_fail++;
          $display("FAIL hold_stable: got rdy=%b %h/%h expected 1 %h/%h%h",
                   cmd_rdy, cmd, data, b[0], b[1], b[2]);
        end
      end
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      #1;
      n_tests++;
      if (cmd_rdy !== 1'b0) begin
        n_fail++; $display("FAIL pkt_clr_rdy: got %b expected 0", cmd_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap_timeout();
    logic c, d, t;
    int drop_at;
    int drops;
    do_reset(1'b1);
    drive_byte(8'h05, c, d, t);
    drive_byte(8'h01, c, d, t);
    drop_at = -1;
    drops   = 0;
    for (int i = 1; i <= GapLimit + 8; i++) begin
      #1;
      if (pkt_drop === 1'b1) begin
        drops++;
        if (drop_at < 0) drop_at = i;
      end
      @(negedge clk);
    end
    n_tests++;
    if (drops != 1) begin
      n_fail++; $display("FAIL gap_drop_count: got %0d expected 1", drops);
    end
    n_tests++;
    if (drop_at < GapLimit - 1 || drop_at > GapLimit + 1) begin
      n_fail++; $display("FAIL gap_drop_time: got %0d expected %0d", drop_at, GapLimit);
    end
    n_tests++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL gap_no_rdy: got %b expected 0", cmd_rdy);
    end
    drive_byte(8'h05, c, d, t);
    drive_byte(8'h00, c, d, t);
    drive_byte(8'h80, c, d, t);
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h05 || data !== 16'h0080) begin
      n_fail++;
      $display("FAIL gap_next_pkt: got rdy=%b %h/%h expected 1 05/0080", cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_wdog_inject();
    int  trip_at;
    logic saw_trmt;
    do_reset(1'b0);
    trip_at = -1;
    for (int i = 0; i < WdogFull + 20; i++) begin
      #1;
      if (wdog_trip === 1'b1) begin
        trip_at = i;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (trip_at < WdogFull - 4 || trip_at > WdogFull + 4) begin
      n_fail++; $display("FAIL wdog_trip_time: got %0d expected %0d", trip_at, WdogFull);
    end
    if (trip_at >= 0) @(negedge clk);
    #1;
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h07 || data !== 16'h0000) begin
      n_fail++;
      $display("FAIL wdog_inject_pkt: got rdy=%b %h/%h expected 1 07/0000", cmd_rdy, cmd, data);
    end
    resp      = 8'hA5;
    send_resp = 1'b1;
    #1;
    saw_trmt = trmt;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (5) begin
      #1;
      saw_trmt = saw_trmt | trmt;
      @(negedge clk);
    end
    n_tests++;
    if (saw_trmt !== 1'b0) begin
      n_fail++; $display("FAIL wdog_resp_suppress: got trmt=%b expected 0", saw_trmt);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_wdog_partial();
    logic c, d, t;
    int  drop_at;
    logic tripped;
    do_reset(1'b0);
    drive_byte(8'h03, c, d, t);
    drop_at = -1;
    for (int i = 1; i < WdogFull + 20; i++) begin
      #1;
      if (pkt_drop === 1'b1) begin
        drop_at = i;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (drop_at < WdogFull - 4 || drop_at > WdogFull + 4) begin
      n_fail++; $display("FAIL wdog_partial_drop: got %0d expected %0d", drop_at, WdogFull);
    end
    tripped = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      tripped = tripped | wdog_trip;
    end
    n_tests++;
    if (tripped !== 1'b1 || cmd !== 8'h07) begin
      n_fail++;
      $display("FAIL wdog_partial_inject: got trip=%b cmd=%h expected 1 07", tripped, cmd);
    end
  endtask

  task automatic test_motors_off();
    logic bad;
    do_reset(1'b1);
    bad = 1'b0;
    repeat (2000) begin
      #1;
      bad = bad | wdog_trip | cmd_rdy | pkt_drop;
      @(negedge clk);
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL motors_off_idle: got activity=%b expected 0", bad);
    end
    motors_off = 1'b0;
    #1;
    n_tests++;
    if (wdog_trip !== 1'b1) begin
      n_fail++; $display("FAIL motors_arm_trip: got %b expected 1", wdog_trip);
    end
    @(negedge clk);
    motors_off = 1'b1;
    #1;
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h07) begin
      n_fail++; $display("FAIL motors_arm_pkt: got rdy=%b cmd=%h expected 1 07", cmd_rdy, cmd);
    end
    @(negedge clk);
  endtask

  task automatic test_host_wins();
    logic c, d, t;
    do_reset(1'b1);
    repeat (WdogFull + 80) @(negedge clk);
    motors_off = 1'b0;
    drive_byte(8'h21, c, d, t);
    n_tests++;
    if (c !== 1'b1 || t !== 1'b0) begin
      n_fail++; $display("FAIL host_wins_first: got clr=%b trip=%b expected 1 0", c, t);
    end
    drive_byte(8'h43, c, d, t);
    drive_byte(8'h65, c, d, t);
    n_tests++;
    if (d !== 1'b0 || cmd_rdy !== 1'b1 || cmd !== 8'h21 || data !== 16'h4365) begin
      n_fail++;
      $display("FAIL host_wins_pkt: got drop=%b rdy=%b %h/%h expected 0 1 21/4365",
               d, cmd_rdy, cmd, data);
    end
    motors_off = 1'b1;
  endtask

  task automatic test_tx_pending();
    do_reset(1'b1);
    resp = 8'h11; send_resp = 1'b1;
    #1;
    n_tests++;
    if (trmt !== 1'b1 || tx_data !== 8'h11) begin
      n_fail++; $display("FAIL tx_direct: got trmt=%b data=%h expected 1 11", trmt, tx_data);
    end
    @(negedge clk);
    resp = 8'hA5;
    #1;
    n_tests++;
    if (trmt !== 1'b0) begin
      n_fail++; $display("FAIL tx_busy_a5: got trmt=%b expected 0", trmt);
    end
    @(negedge clk);
    resp = 8'h5A;
    #1;
    n_tests++;
    if (trmt !== 1'b0 || tx_data !== 8'h11) begin
      n_fail++; $display("FAIL tx_busy_5a: got trmt=%b data=%h expected 0 11", trmt, tx_data);
    end
    @(negedge clk);
    send_resp = 1'b0;
    repeat (3) @(negedge clk);
    tx_done = 1'b1;
    #1;
    n_tests++;
    if (trmt !== 1'b1 || tx_data !== 8'h5A) begin
      n_fail++; $display("FAIL tx_pend_send: got trmt=%b data=%h expected 1 5A", trmt, tx_data);
    end
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    n_tests++;
    if (trmt !== 1'b0 || tx_data !== 8'h5A) begin
      n_fail++; $display("FAIL tx_hold: got trmt=%b data=%h expected 0 5A", trmt, tx_data);
    end
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    n_tests++;
    if (trmt !== 1'b0) begin
      n_fail++; $display("FAIL tx_no_extra: got trmt=%b expected 0", trmt);
    end
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Model: one byte on the wire at a time, at most one waiting, newest waiting wins.
  task automatic test_tx_random();
    logic       busy, have_pend, exp_trmt, free, done_now, send_now;
    logic [7:0] pend, last, exp_data, r;
    do_reset(1'b1);
    busy = 1'b0; have_pend = 1'b0; pend = 8'h00; last = 8'h00;
    for (int i = 0; i < 300; i++) begin
      send_now  = ($urandom_range(0, 9) < 4);
      done_now  = busy && ($urandom_range(0, 3) == 0);
      r         = 8'($urandom);
      send_resp = send_now;
      resp      = r;
      tx_done   = done_now;
      #1;
      free     = !busy || done_now;
      exp_trmt = 1'b0;
      exp_data = last;
      if (free && have_pend) begin
        exp_trmt  = 1'b1;
        exp_data  = pend;
        have_pend = 1'b0;
      end
      if (send_now) begin
        if (free && !exp_trmt) begin
          exp_trmt = 1'b1;
          exp_data = r;
        end else begin
          pend      = r;
          have_pend = 1'b1;
        end
      end
      busy = exp_trmt || (busy && !done_now);
      last = exp_data;
      n_tests++;
      if (trmt !== exp_trmt || tx_data !== exp_data) begin
        n_fail++;
        $display("FAIL tx_random[%0d]: got trmt=%b data=%h expected %b %h",
                 i, trmt, tx_data, exp_trmt, exp_data);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_packets();
    test_gap_timeout();
    test_wdog_inject();
    test_wdog_partial();
    test_motors_off();
    test_host_wins();
    test_tx_pending();
    test_tx_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
